// File: rtl/dma_txn_tracker_pkg.sv
// Shared types for the DMA transaction tracker: drain FSM states, fault counter width
// and the default AXI request/response structs of the DMA master port.
package dma_txn_tracker_pkg;

   localparam int unsigned FaultCntWidth = 8;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StDrained
   } drain_state_e;

   // Address channel, including the IOMMU stream/substream identifiers.
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [15:0] stream_id;
      logic        ss_id_valid;
      logic [19:0] substream_id;
   } axi_ax_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } axi_w_chan_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } axi_b_chan_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } axi_r_chan_t;

   typedef struct packed {
      axi_ax_chan_t aw;
      logic         aw_valid;
      axi_w_chan_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_ax_chan_t ar;
      logic         ar_valid;
      logic         r_ready;
   } dma_axi_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        ar_ready;
      logic        w_ready;
      logic        b_valid;
      axi_b_chan_t b;
      logic        r_valid;
      axi_r_chan_t r;
   } dma_axi_rsp_t;

endpackage

// File: rtl/dma_txn_counter.sv
// Outstanding-transaction counter: +1 on admission, -1 on retirement, with limit and
// zero flags for the admission gate.
module dma_txn_counter #(
   parameter int unsigned Max = 8,
   localparam int unsigned CntW = $clog2(Max + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            inc_i,
   input  logic            dec_i,
   output logic [CntW-1:0] cnt_o,
   output logic            below_max_o,
   output logic            zero_o
);

   logic [CntW-1:0] cnt_d, cnt_q;

   // Next count; a simultaneous increment and decrement cancel out.
   always_comb begin
      cnt_d = cnt_q;
      unique case ({inc_i, dec_i})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o       = cnt_q;
   assign below_max_o = (cnt_q < CntW'(Max));
   assign zero_o      = (cnt_q == '0);

   // The admission gate upstream must keep the count inside [0, Max].
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(inc_i && !dec_i && (cnt_q == CntW'(Max))));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec_i && !inc_i && (cnt_q == '0)));

endmodule

// File: rtl/dma_txn_tracker.sv
// AXI pass-through between the DMA master port and the IOMMU that caps outstanding
// read/write bursts, offers a drain handshake and records IOMMU fault responses.
module dma_txn_tracker
   import dma_txn_tracker_pkg::*;
#(
   parameter int unsigned MaxRdTxns = 8,
   parameter int unsigned MaxWrTxns = 8,
   parameter type axi_req_t = dma_axi_req_t,
   parameter type axi_rsp_t = dma_axi_rsp_t,
   localparam int unsigned RdCntW = $clog2(MaxRdTxns + 1),
   localparam int unsigned WrCntW = $clog2(MaxWrTxns + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  axi_req_t                 slv_req_i,
   output axi_rsp_t                 slv_rsp_o,
   output axi_req_t                 mst_req_o,
   input  axi_rsp_t                 mst_rsp_i,
   input  logic                     drain_req_i,
   output logic                     drain_ack_o,
   output logic                     idle_o,
   output logic [RdCntW-1:0]        rd_cnt_o,
   output logic [WrCntW-1:0]        wr_cnt_o,
   output logic                     fault_irq_o,
   input  logic                     fault_clr_i,
   output logic [FaultCntWidth-1:0] rd_fault_cnt_o,
   output logic [FaultCntWidth-1:0] wr_fault_cnt_o
);

   localparam logic [FaultCntWidth-1:0] FaultCntMax = '1;

   drain_state_e             state_q;
   logic                     ar_hold_q, aw_hold_q, ar_hold_d, aw_hold_d;
   logic                     ar_allow, aw_allow;
   logic                     ar_hs, aw_hs, r_last_hs, b_hs;
   logic                     rd_below_max, wr_below_max, rd_zero, wr_zero;
   logic                     rd_zero_nxt, wr_zero_nxt;
   logic                     rd_fault, wr_fault;
   logic                     fault_irq_q;
   logic [FaultCntWidth-1:0] rd_fault_cnt_q, wr_fault_cnt_q;

   // A held request must always be allowed to finish, whatever the state or count.
   assign ar_allow = ar_hold_q | ((state_q == StRun) & rd_below_max);
   assign aw_allow = aw_hold_q | ((state_q == StRun) & wr_below_max);

   // Combinational pass-through; only the AR/AW handshakes are gated.
   always_comb begin
      mst_req_o          = slv_req_i;
      mst_req_o.ar_valid = slv_req_i.ar_valid & ar_allow;
      mst_req_o.aw_valid = slv_req_i.aw_valid & aw_allow;
      slv_rsp_o          = mst_rsp_i;
      slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_allow;
      slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_allow;
   end

   assign ar_hs     = slv_req_i.ar_valid & ar_allow & mst_rsp_i.ar_ready;
   assign aw_hs     = slv_req_i.aw_valid & aw_allow & mst_rsp_i.aw_ready;
   assign r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
   assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;

   // Presented downstream but not accepted: keep valid up until the handshake.
   assign ar_hold_d = slv_req_i.ar_valid & ar_allow & ~mst_rsp_i.ar_ready;
   assign aw_hold_d = slv_req_i.aw_valid & aw_allow & ~mst_rsp_i.aw_ready;

   dma_txn_counter #(
      .Max (MaxRdTxns)
   ) u_rd_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (ar_hs),
      .dec_i       (r_last_hs),
      .cnt_o       (rd_cnt_o),
      .below_max_o (rd_below_max),
      .zero_o      (rd_zero)
   );

   dma_txn_counter #(
      .Max (MaxWrTxns)
   ) u_wr_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (aw_hs),
      .dec_i       (b_hs),
      .cnt_o       (wr_cnt_o),
      .below_max_o (wr_below_max),
      .zero_o      (wr_zero)
   );

   // Post-edge emptiness, so drain_ack can rise right after the last response.
   assign rd_zero_nxt = ~ar_hs & (rd_zero | ((rd_cnt_o == RdCntW'(1)) & r_last_hs));
   assign wr_zero_nxt = ~aw_hs & (wr_zero | ((wr_cnt_o == WrCntW'(1)) & b_hs));

   // Drain FSM and AR/AW hold registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StRun;
         ar_hold_q <= 1'b0;
         aw_hold_q <= 1'b0;
      end else begin
         ar_hold_q <= ar_hold_d;
         aw_hold_q <= aw_hold_d;
         unique case (state_q)
            StRun: begin
               if (drain_req_i) state_q <= StDrain;
            end
            StDrain: begin
               if (!drain_req_i) begin
                  state_q <= StRun;
               end else if (rd_zero_nxt && wr_zero_nxt && !ar_hold_d && !aw_hold_d) begin
                  state_q <= StDrained;
               end
            end
            StDrained: begin
               if (!drain_req_i) state_q <= StRun;
            end
            default: state_q <= StRun;
         endcase
      end
   end

   assign rd_fault = r_last_hs & mst_rsp_i.r.resp[1];
   assign wr_fault = b_hs & mst_rsp_i.b.resp[1];

   // Sticky fault flag and saturating counters; a fault beats a same-cycle clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fault_irq_q    <= 1'b0;
         rd_fault_cnt_q <= '0;
         wr_fault_cnt_q <= '0;
      end else if (fault_clr_i) begin
         fault_irq_q    <= rd_fault | wr_fault;
         rd_fault_cnt_q <= FaultCntWidth'(rd_fault);
         wr_fault_cnt_q <= FaultCntWidth'(wr_fault);
      end else begin
         if (rd_fault | wr_fault) fault_irq_q <= 1'b1;
         if (rd_fault && (rd_fault_cnt_q != FaultCntMax)) begin
            rd_fault_cnt_q <= rd_fault_cnt_q + 1'b1;
         end
         if (wr_fault && (wr_fault_cnt_q != FaultCntMax)) begin
            wr_fault_cnt_q <= wr_fault_cnt_q + 1'b1;
         end
      end
   end

   assign drain_ack_o    = (state_q == StDrained);
   assign idle_o         = rd_zero & wr_zero;
   assign fault_irq_o    = fault_irq_q;
   assign rd_fault_cnt_o = rd_fault_cnt_q;
   assign wr_fault_cnt_o = wr_fault_cnt_q;

endmodule

// File: tb/tb_dma_txn_tracker.sv
// Bench for dma_txn_tracker: directed scenarios with literal expectations, then random
// AXI traffic, all checked every cycle against a transaction-level model.
module tb_dma_txn_tracker;
   import dma_txn_tracker_pkg::*;

   localparam int MaxRd = 3;
   localparam int MaxWr = 2;
   localparam int MRun = 0, MDrain = 1, MDrained = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   dma_axi_req_t slv_req, mst_req, exp_req;
   dma_axi_rsp_t slv_rsp, mst_rsp, exp_rsp;
   logic         drain_req, drain_ack, idle, fault_irq, fault_clr;
   logic [1:0]   rd_cnt, wr_cnt;
   logic [7:0]   rd_fault_cnt, wr_fault_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // Model: outstanding bursts, pending (presented, unaccepted) requests, drain mode, faults.
   int m_rd, m_wr, m_mode, m_rdf, m_wrf;
   bit m_arp, m_awp, m_irq, m_ar_adm, m_aw_adm;
   bit m_ar_hs, m_aw_hs, m_rl_hs, m_b_hs, m_rf, m_wf;

   // Driver bookkeeping for legal random stimulus.
   int drv_rd, drv_wr;
   bit ar_acc, aw_acc, r_acc, b_acc;

   always #5 clk = ~clk;

   dma_txn_tracker #(
      .MaxRdTxns (MaxRd),
      .MaxWrTxns (MaxWr),
      .axi_req_t (dma_axi_req_t),
      .axi_rsp_t (dma_axi_rsp_t)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .slv_req_i      (slv_req),
      .slv_rsp_o      (slv_rsp),
      .mst_req_o      (mst_req),
      .mst_rsp_i      (mst_rsp),
      .drain_req_i    (drain_req),
      .drain_ack_o    (drain_ack),
      .idle_o         (idle),
      .rd_cnt_o       (rd_cnt),
      .wr_cnt_o       (wr_cnt),
      .fault_irq_o    (fault_irq),
      .fault_clr_i    (fault_clr),
      .rd_fault_cnt_o (rd_fault_cnt),
      .wr_fault_cnt_o (wr_fault_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      slv_req   = '0;
      mst_rsp   = '0;
      drain_req = 1'b0;
      fault_clr = 1'b0;
   endtask

   // Compare process: check DUT against the model mid-cycle, then advance the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_rd = 0; m_wr = 0; m_mode = MRun; m_rdf = 0; m_wrf = 0;
         m_arp = 0; m_awp = 0; m_irq = 0;
         check("rst_rd_cnt", 32'(rd_cnt), 0);
         check("rst_idle", 32'(idle), 1);
         check("rst_drain_ack", 32'(drain_ack), 0);
         check("rst_fault_irq", 32'(fault_irq), 0);
      end else begin
         m_ar_adm = m_arp || (m_mode == MRun && m_rd < MaxRd);
         m_aw_adm = m_awp || (m_mode == MRun && m_wr < MaxWr);
         exp_req = slv_req;
         exp_req.ar_valid = slv_req.ar_valid && m_ar_adm;
         exp_req.aw_valid = slv_req.aw_valid && m_aw_adm;
         exp_rsp = mst_rsp;
         exp_rsp.ar_ready = mst_rsp.ar_ready && m_ar_adm;
         exp_rsp.aw_ready = mst_rsp.aw_ready && m_aw_adm;
         check("mdl_mst_ar_valid", 32'(mst_req.ar_valid), 32'(exp_req.ar_valid));
         check("mdl_slv_ar_ready", 32'(slv_rsp.ar_ready), 32'(exp_rsp.ar_ready));
         check("mdl_mst_aw_valid", 32'(mst_req.aw_valid), 32'(exp_req.aw_valid));
         check("mdl_slv_aw_ready", 32'(slv_rsp.aw_ready), 32'(exp_rsp.aw_ready));
         n_chk++;
         if (mst_req !== exp_req) begin
            n_fail++;
            $display("FAIL mdl_mst_req: got %h, expected %h", mst_req, exp_req);
         end
         n_chk++;
         if (slv_rsp !== exp_rsp) begin
            n_fail++;
            $display("FAIL mdl_slv_rsp: got %h, expected %h", slv_rsp, exp_rsp);
         end
         check("mdl_rd_cnt", 32'(rd_cnt), m_rd);
         check("mdl_wr_cnt", 32'(wr_cnt), m_wr);
         check("mdl_idle", 32'(idle), 32'(m_rd == 0 && m_wr == 0));
         check("mdl_drain_ack", 32'(drain_ack), 32'(m_mode == MDrained));
         check("mdl_fault_irq", 32'(fault_irq), 32'(m_irq));
         check("mdl_rd_fault_cnt", 32'(rd_fault_cnt), m_rdf);
         check("mdl_wr_fault_cnt", 32'(wr_fault_cnt), m_wrf);

         m_ar_hs = exp_req.ar_valid && mst_rsp.ar_ready;
         m_aw_hs = exp_req.aw_valid && mst_rsp.aw_ready;
         m_rl_hs = mst_rsp.r_valid && slv_req.r_ready && mst_rsp.r.last;
         m_b_hs  = mst_rsp.b_valid && slv_req.b_ready;
         m_rd    = m_rd + int'(m_ar_hs) - int'(m_rl_hs);
         m_wr    = m_wr + int'(m_aw_hs) - int'(m_b_hs);
         m_arp   = exp_req.ar_valid && !mst_rsp.ar_ready;
         m_awp   = exp_req.aw_valid && !mst_rsp.aw_ready;
         case (m_mode)
            MRun:    if (drain_req) m_mode = MDrain;
            MDrain:  if (!drain_req) m_mode = MRun;
                     else if (m_rd == 0 && m_wr == 0 && !m_arp && !m_awp) m_mode = MDrained;
            default: if (!drain_req) m_mode = MRun;
         endcase
         m_rf = m_rl_hs && mst_rsp.r.resp[1];
         m_wf = m_b_hs && mst_rsp.b.resp[1];
         if (fault_clr) begin
            m_irq = m_rf || m_wf;
            m_rdf = int'(m_rf);
            m_wrf = int'(m_wf);
         end else begin
            if (m_rf || m_wf) m_irq = 1;
            if (m_rf && m_rdf < 255) m_rdf++;
            if (m_wf && m_wrf < 255) m_wrf++;
         end
      end
   end

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("reset_rd_cnt", 32'(rd_cnt), 0);
      check("reset_idle", 32'(idle), 1);
      check("reset_drain_ack", 32'(drain_ack), 0);
      check("reset_fault_irq", 32'(fault_irq), 0);

      // Outstanding limit: MaxRd back-to-back ARs accepted, the next one stalls.
      slv_req.ar_valid = 1; slv_req.ar.addr = 32'h1000; mst_rsp.ar_ready = 1;
      slv_req.r_ready = 1; mst_rsp.r.last = 1;
      for (int i = 0; i < MaxRd; i++) begin
         #1 check("lim_ar_ready", 32'(slv_rsp.ar_ready), 1);
         tick();
         check("lim_rd_cnt", 32'(rd_cnt), i + 1);
      end
      #1 check("lim_stall_ready", 32'(slv_rsp.ar_ready), 0);
      check("lim_stall_valid", 32'(mst_req.ar_valid), 0);
      tick();
      mst_rsp.r_valid = 1;
      #1 check("lim_rlast_cycle_ready", 32'(slv_rsp.ar_ready), 0);
      tick();
      mst_rsp.r_valid = 0;
      #1 check("lim_unblock_ready", 32'(slv_rsp.ar_ready), 1);
      check("lim_rd_cnt_after_r", 32'(rd_cnt), MaxRd - 1);
      tick();
      slv_req.ar_valid = 0;
      #1 check("lim_rd_cnt_refill", 32'(rd_cnt), MaxRd);

      // Retire down to one, then AR handshake and R last in the same cycle.
      mst_rsp.r_valid = 1;
      repeat (MaxRd - 1) tick();
      slv_req.ar_valid = 1;
      tick();
      slv_req.ar_valid = 0; mst_rsp.r_valid = 0;
      #1 check("simul_rd_cnt", 32'(rd_cnt), 1);
      check("simul_idle", 32'(idle), 0);
      mst_rsp.r_valid = 1;
      tick();
      mst_rsp.r_valid = 0;
      #1 check("simul_retire_rd_cnt", 32'(rd_cnt), 0);

      // Drain with one write outstanding.
      slv_req.aw_valid = 1; mst_rsp.aw_ready = 1; slv_req.b_ready = 1;
      tick();
      slv_req.aw_valid = 0;
      #1 check("drn_wr_cnt", 32'(wr_cnt), 1);
      drain_req = 1;
      tick();
      slv_req.aw_valid = 1; slv_req.aw.addr = 32'h2000;
      #1 check("drn_aw_blocked", 32'(mst_req.aw_valid), 0);
      check("drn_ack_pending", 32'(drain_ack), 0);
      tick();
      mst_rsp.b_valid = 1; mst_rsp.b.resp = 2'b00;
      #1 check("drn_ack_b_cycle", 32'(drain_ack), 0);
      tick();
      mst_rsp.b_valid = 0;
      #1 check("drn_ack", 32'(drain_ack), 1);
      check("drn_wr_zero", 32'(wr_cnt), 0);
      check("drn_aw_still_blocked", 32'(mst_req.aw_valid), 0);
      drain_req = 0;
      #1 check("drn_release_aw_blocked", 32'(mst_req.aw_valid), 0);
      tick();
      #1 check("drn_aw_admitted", 32'(mst_req.aw_valid), 1);
      check("drn_ack_dropped", 32'(drain_ack), 0);
      tick();
      slv_req.aw_valid = 0;
      #1 check("drn_aw_counted", 32'(wr_cnt), 1);

      // Write fault.
      mst_rsp.b_valid = 1; mst_rsp.b.resp = 2'b10;
      tick();
      mst_rsp.b_valid = 0; mst_rsp.b.resp = 2'b00;
      #1 check("wflt_irq", 32'(fault_irq), 1);
      check("wflt_cnt", 32'(wr_fault_cnt), 1);

      // Stability: a held AR keeps valid across a drain request until accepted.
      mst_rsp.ar_ready = 0; slv_req.ar_valid = 1; slv_req.ar.addr = 32'h3000;
      #1 check("stab_valid_first", 32'(mst_req.ar_valid), 1);
      tick();
      drain_req = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check("stab_valid_hold", 32'(mst_req.ar_valid), 1);
         tick();
      end
      mst_rsp.ar_ready = 1;
      tick();
      slv_req.ar_valid = 0;
      #1 check("stab_rd_cnt", 32'(rd_cnt), 1);
      check("stab_no_ack", 32'(drain_ack), 0);
      tick();
      #1 check("stab_no_ack_later", 32'(drain_ack), 0);
      mst_rsp.r_valid = 1; mst_rsp.r.resp = 2'b00;
      tick();
      mst_rsp.r_valid = 0;
      #1 check("stab_ack", 32'(drain_ack), 1);
      drain_req = 0;
      tick();

      // Read fault in the same cycle as a clear: the fault wins.
      slv_req.ar_valid = 1;
      tick();
      slv_req.ar_valid = 0;
      mst_rsp.r_valid = 1; mst_rsp.r.resp = 2'b11; fault_clr = 1;
      tick();
      mst_rsp.r_valid = 0; mst_rsp.r.resp = 2'b00; fault_clr = 0;
      #1 check("clr_irq", 32'(fault_irq), 1);
      check("clr_rd_fault", 32'(rd_fault_cnt), 1);
      check("clr_wr_fault", 32'(wr_fault_cnt), 0);

      // 300 write faults saturate at 255.
      fault_clr = 1;
      tick();
      fault_clr = 0;
      #1 check("sat_cleared_irq", 32'(fault_irq), 0);
      slv_req.aw_valid = 1;
      tick();
      mst_rsp.b_valid = 1; mst_rsp.b.resp = 2'b10;
      repeat (300) tick();
      slv_req.aw_valid = 0;
      #1 check("sat_wr_fault", 32'(wr_fault_cnt), 255);
      check("sat_wr_cnt", 32'(wr_cnt), 1);
      tick();
      mst_rsp.b_valid = 0; mst_rsp.b.resp = 2'b00;
      #1 check("sat_wr_fault_hold", 32'(wr_fault_cnt), 255);
      check("sat_wr_cnt_zero", 32'(wr_cnt), 0);

      // Reset mid-burst with three reads outstanding.
      slv_req.ar_valid = 1;
      repeat (3) tick();
      slv_req.ar_valid = 0;
      #1 check("rstm_rd_cnt", 32'(rd_cnt), 3);
      check("rstm_irq_set", 32'(fault_irq), 1);
      mst_rsp.r_valid = 1; mst_rsp.r.last = 0;
      tick();
      rst_n = 0;
      idle_inputs();
      #1 check("rstm_rd_cnt_zero", 32'(rd_cnt), 0);
      check("rstm_idle", 32'(idle), 1);
      check("rstm_drain_ack", 32'(drain_ack), 0);
      check("rstm_irq", 32'(fault_irq), 0);
      tick();
      tick();
      rst_n = 1;

      // Random traffic; valids are held until their handshake, responses only when owed.
      drv_rd = 0; drv_wr = 0;
      ar_acc = 1; aw_acc = 1; r_acc = 1; b_acc = 1;
      for (int c = 0; c < 3000; c++) begin
         if (!(slv_req.ar_valid && !ar_acc)) begin
            slv_req.ar_valid = 1'($urandom_range(0, 1));
            slv_req.ar.addr = $urandom;
            slv_req.ar.stream_id = 16'($urandom);
            slv_req.ar.substream_id = 20'($urandom);
            slv_req.ar.ss_id_valid = 1'($urandom);
         end
         if (!(slv_req.aw_valid && !aw_acc)) begin
            slv_req.aw_valid = 1'($urandom_range(0, 1));
            slv_req.aw.addr = $urandom;
            slv_req.aw.stream_id = 16'($urandom);
         end
         if (!(mst_rsp.r_valid && !r_acc)) begin
            mst_rsp.r_valid = (drv_rd > 0) && ($urandom_range(0, 1) == 1);
            mst_rsp.r.last = 1'($urandom_range(0, 1));
            mst_rsp.r.resp = 2'($urandom);
            mst_rsp.r.data = {$urandom, $urandom};
         end
         if (!(mst_rsp.b_valid && !b_acc)) begin
            mst_rsp.b_valid = (drv_wr > 0) && ($urandom_range(0, 1) == 1);
            mst_rsp.b.resp = 2'($urandom);
            mst_rsp.b.id = 4'($urandom);
         end
         mst_rsp.ar_ready = ($urandom_range(0, 9) < 6);
         mst_rsp.aw_ready = ($urandom_range(0, 9) < 6);
         slv_req.r_ready = 1'($urandom_range(0, 1));
         slv_req.b_ready = 1'($urandom_range(0, 1));
         slv_req.w_valid = 1'($urandom_range(0, 1));
         slv_req.w.data = {$urandom, $urandom};
         mst_rsp.w_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
         fault_clr = ($urandom_range(0, 19) == 0);
         @(negedge clk);
         ar_acc = slv_req.ar_valid && slv_rsp.ar_ready;
         aw_acc = slv_req.aw_valid && slv_rsp.aw_ready;
         r_acc = mst_rsp.r_valid && slv_req.r_ready;
         b_acc = mst_rsp.b_valid && slv_req.b_ready;
         drv_rd = drv_rd + int'(mst_req.ar_valid && mst_rsp.ar_ready)
                  - int'(r_acc && mst_rsp.r.last);
         drv_wr = drv_wr + int'(mst_req.aw_valid && mst_rsp.aw_ready) - int'(b_acc);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
